// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, fetches one instruction per commit over a
// valid/ready read channel and latches the first fetch fault until reset.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_ARVALID,
    output logic [31:0] IMEM_ARADDR,
    input  logic        IMEM_ARREADY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA_I,
    input  logic [1:0]  IMEM_RRESP,
    output logic        IMEM_RREADY,
    output logic [31:0] PC,
    output logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    input  logic [31:0] PC_N,
    input  logic        INSTR_DONE,
    output logic        FETCH_ERR,
    output logic [1:0]  ERR_CAUSE,
    output logic [31:0] INSTRET
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_EXEC,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    logic [31:0] tmo_cnt_q;
    logic [31:0] tmo_cnt_d;
    logic        tmo_hit;
    logic        arvalid_q;
    logic        rready_q;
    logic        valid_q;
    logic        err_q;
    logic [1:0]  cause_q;

    // tmo_cnt_d is the number of S_RESP cycles completed at the coming edge.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TIMEOUT_CYCLES);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_VECTOR;
            instr_q   <= NOP_INSTR;
            instret_q <= '0;
            tmo_cnt_q <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_REQ;
                    arvalid_q <= 1'b1;
                end
                S_REQ: begin
                    if (IMEM_ARREADY) begin
                        state_q   <= S_RESP;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                    end
                end
                S_RESP: begin
                    // A response in the limit cycle wins over the timeout.
                    if (IMEM_RVALID) begin
                        rready_q  <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (IMEM_RRESP == 2'b00) begin
                            instr_q <= IMEM_RDATA_I;
                            valid_q <= 1'b1;
                            state_q <= S_EXEC;
                        end else begin
                            err_q   <= 1'b1;
                            cause_q <= 2'b01;
                            state_q <= S_ERR;
                        end
                    end else if (tmo_hit) begin
                        rready_q  <= 1'b0;
                        tmo_cnt_q <= '0;
                        err_q     <= 1'b1;
                        cause_q   <= 2'b11;
                        state_q   <= S_ERR;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_EXEC: begin
                    if (INSTR_DONE) begin
                        valid_q <= 1'b0;
                        if (PC_N[1:0] == 2'b00) begin
                            pc_q      <= PC_N;
                            instret_q <= instret_q + 32'd1;
                            arvalid_q <= 1'b1;
                            state_q   <= S_REQ;
                        end else begin
                            err_q   <= 1'b1;
                            cause_q <= 2'b10;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign IMEM_ARVALID = arvalid_q;
    assign IMEM_ARADDR  = pc_q;
    assign IMEM_RREADY  = rready_q;
    assign PC           = pc_q;
    assign IMEM_RDATA   = instr_q;
    assign INSTR_VALID  = valid_q;
    assign FETCH_ERR    = err_q;
    assign ERR_CAUSE    = cause_q;
    assign INSTRET      = instret_q;

endmodule
